// File: rtl/ram_arbiter_if.sv
// Client request/response and byte-wide RAM/IO bus bundle for ram_arbiter.
// The arbiter connects through slave; the CPU clients and RAM connect through master.
interface ram_arbiter_if;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        busy;

    modport slave (
        input  rdy, if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
    );

    modport master (
        output rdy, if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Byte-serial scheduler granting IF or MEM access to one 8-bit RAM/IO bus,
// assembling little-endian read words and honouring rdy pauses with read replay.
module ram_arbiter #(
    parameter int unsigned MEM_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  last;
    logic        owner_mem;
    logic        we;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] asm_q;
    logic        replay;
    logic [31:0] replay_a;
    logic [31:0] a_q;
    logic        wr_q;
    logic [7:0]  dout_q;
    logic        if_done_q;
    logic        mem_done_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;

    logic        mem_win;
    logic        grant;
    logic [1:0]  req_last;
    logic [1:0]  cap_idx;
    logic [1:0]  idx_p1;
    logic        replay_start;
    logic [31:0] asm_cap;

    assign mem_win      = bus.mem_req && ((MEM_FIRST != 0) || !bus.if_req);
    assign grant        = bus.mem_req || bus.if_req;
    assign cap_idx      = (state == DRAIN) ? last : (idx - 2'd1);
    assign idx_p1       = idx + 2'd1;
    // The RAM pipeline loses the outstanding read byte across a pause
    assign replay_start = ((state == ISSUE) && !we && (idx != 2'd0)) || (state == DRAIN);

    always_comb begin
        req_last = 2'd3;
        if (mem_win) begin
            case (bus.mem_size)
                2'd0:    req_last = 2'd0;
                2'd1:    req_last = 2'd1;
                default: req_last = 2'd3;
            endcase
        end
    end

    always_comb begin
        asm_cap = asm_q;
        asm_cap[{cap_idx, 3'b000} +: 8] = bus.ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 2'd0;
            last        <= 2'd0;
            owner_mem   <= 1'b0;
            we          <= 1'b0;
            base        <= 32'd0;
            wdata       <= 32'd0;
            asm_q       <= 32'd0;
            replay      <= 1'b0;
            replay_a    <= 32'd0;
            a_q         <= 32'd0;
            wr_q        <= 1'b0;
            dout_q      <= 8'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else if (!bus.rdy) begin
            if (replay_start) begin
                replay   <= 1'b1;
                replay_a <= base + 32'(cap_idx);
            end
        end else if (replay) begin
            replay <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= ISSUE;
                        idx       <= 2'd0;
                        last      <= req_last;
                        owner_mem <= mem_win;
                        we        <= mem_win && bus.mem_we;
                        base      <= mem_win ? bus.mem_addr : bus.if_addr;
                        wdata     <= bus.mem_wdata;
                        asm_q     <= 32'd0;
                        a_q       <= mem_win ? bus.mem_addr : bus.if_addr;
                        wr_q      <= mem_win && bus.mem_we;
                        dout_q    <= (mem_win && bus.mem_we) ? bus.mem_wdata[7:0] : 8'd0;
                    end
                end
                ISSUE: begin
                    if (!we && (idx != 2'd0)) begin
                        asm_q <= asm_cap;
                    end
                    if (idx == last) begin
                        a_q    <= 32'd0;
                        wr_q   <= 1'b0;
                        dout_q <= 8'd0;
                        if (we) begin
                            state       <= DONE;
                            mem_done_q  <= 1'b1;
                            mem_rdata_q <= asm_q;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idx    <= idx_p1;
                        a_q    <= base + 32'(idx_p1);
                        wr_q   <= we;
                        dout_q <= we ? wdata[{idx_p1, 3'b000} +: 8] : 8'd0;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    asm_q <= asm_cap;
                    if (owner_mem) begin
                        mem_done_q  <= 1'b1;
                        mem_rdata_q <= asm_cap;
                    end else begin
                        if_done_q <= 1'b1;
                        if_data_q <= asm_cap;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    if_done_q  <= 1'b0;
                    mem_done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A pause suppresses writes and done pulses in the cycle it is seen
    assign bus.ram_a     = (replay && bus.rdy) ? replay_a : a_q;
    assign bus.ram_wr    = wr_q && bus.rdy;
    assign bus.ram_dout  = dout_q;
    assign bus.if_done   = if_done_q && bus.rdy;
    assign bus.mem_done  = mem_done_q && bus.rdy;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed cycle-by-cycle bench for ram_arbiter with hand-computed bus and data values.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] fetch_b [4] = '{8'h13, 8'h05, 8'h10, 8'h00};
    logic [7:0] st_b    [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] if2_b   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    ram_arbiter_if b ();
    ram_arbiter #(.MEM_FIRST(1)) dut (.clk(clk), .rst(rst), .bus(b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        b.rdy = 1'b1; b.if_req = 1'b0; b.if_addr = 32'd0;
        b.mem_req = 1'b0; b.mem_we = 1'b0; b.mem_size = 2'd0;
        b.mem_addr = 32'd0; b.mem_wdata = 32'd0; b.ram_din = 8'd0;
        cyc(); cyc();
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_ram_a", b.ram_a, 32'd0);
        chk("rst_ram_wr", 32'(b.ram_wr), 32'd0);
        chk("rst_ram_dout", 32'(b.ram_dout), 32'd0);
        chk("rst_if_done", 32'(b.if_done), 32'd0);
        chk("rst_mem_done", 32'(b.mem_done), 32'd0);
        chk("rst_if_data", b.if_data, 32'd0);
        chk("rst_mem_rdata", b.mem_rdata, 32'd0);
        rst = 1'b0;

        // word fetch at 0x10
        b.if_req = 1'b1; b.if_addr = 32'h10;
        chk("fetch_c0_busy", 32'(b.busy), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k >= 2) b.ram_din = fetch_b[k-2];
            chk($sformatf("fetch_a_c%0d", k), b.ram_a, 32'(32'h10 + k - 1));
            chk($sformatf("fetch_wr_c%0d", k), 32'(b.ram_wr), 32'd0);
        end
        cyc(); b.ram_din = fetch_b[3];
        chk("fetch_drain_a", b.ram_a, 32'd0);
        chk("fetch_c5_done", 32'(b.if_done), 32'd0);
        cyc();
        chk("fetch_c6_done", 32'(b.if_done), 32'd1);
        chk("fetch_data", b.if_data, 32'h00100513);
        b.if_req = 1'b0;
        cyc();
        chk("fetch_c7_done", 32'(b.if_done), 32'd0);
        chk("fetch_c7_busy", 32'(b.busy), 32'd0);
        chk("fetch_hold", b.if_data, 32'h00100513);

        // store word 0xDEADBEEF at 0x100
        b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_size = 2'd2;
        b.mem_addr = 32'h100; b.mem_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("st_wr_c%0d", k + 1), 32'(b.ram_wr), 32'd1);
            chk($sformatf("st_a_c%0d", k + 1), b.ram_a, 32'(32'h100 + k));
            chk($sformatf("st_dout_c%0d", k + 1), 32'(b.ram_dout), 32'(st_b[k]));
        end
        cyc();
        chk("st_done", 32'(b.mem_done), 32'd1);
        chk("st_c5_wr", 32'(b.ram_wr), 32'd0);
        chk("st_c5_dout", 32'(b.ram_dout), 32'd0);
        b.mem_req = 1'b0; b.mem_we = 1'b0;
        cyc();
        chk("st_c6_busy", 32'(b.busy), 32'd0);
        chk("st_c6_done", 32'(b.mem_done), 32'd0);

        // simultaneous requests, MEM byte load at I/O 0x30000 wins
        b.if_req = 1'b1; b.if_addr = 32'h200;
        b.mem_req = 1'b1; b.mem_size = 2'd0; b.mem_addr = 32'h30000;
        cyc();
        chk("arb_c1_a", b.ram_a, 32'h30000);
        chk("arb_c1_wr", 32'(b.ram_wr), 32'd0);
        cyc(); b.ram_din = 8'h41;
        chk("arb_c2_a", b.ram_a, 32'd0);
        cyc();
        chk("arb_mem_done", 32'(b.mem_done), 32'd1);
        chk("arb_if_done", 32'(b.if_done), 32'd0);
        chk("arb_rdata", b.mem_rdata, 32'h00000041);
        chk("arb_c3_a", b.ram_a, 32'd0);
        b.mem_req = 1'b0;
        cyc();
        chk("arb_idle_busy", 32'(b.busy), 32'd0);
        chk("arb_idle_a", b.ram_a, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k >= 2) b.ram_din = if2_b[k-2];
            chk($sformatf("arb_if_a_c%0d", k), b.ram_a, 32'(32'h200 + k - 1));
        end
        cyc(); b.ram_din = if2_b[3];
        chk("arb_if_c5_done", 32'(b.if_done), 32'd0);
        cyc();
        chk("arb_if_c6_done", 32'(b.if_done), 32'd1);
        chk("arb_if_data", b.if_data, 32'h44332211);
        b.if_req = 1'b0;
        cyc();

        // half load wrapping past 0xFFFFFFFF
        b.mem_req = 1'b1; b.mem_size = 2'd1; b.mem_addr = 32'hFFFFFFFF;
        cyc();
        chk("half_c1_a", b.ram_a, 32'hFFFFFFFF);
        cyc(); b.ram_din = 8'hAB;
        chk("half_c2_a", b.ram_a, 32'h00000000);
        cyc(); b.ram_din = 8'hCD;
        chk("half_c3_done", 32'(b.mem_done), 32'd0);
        cyc();
        chk("half_c4_done", 32'(b.mem_done), 32'd1);
        chk("half_rdata", b.mem_rdata, 32'h0000CDAB);
        b.mem_req = 1'b0;
        cyc();

        // word fetch with rdy low in cycles 3-5
        b.if_req = 1'b1; b.if_addr = 32'h40;
        cyc();
        chk("pz_c1_a", b.ram_a, 32'h40);
        cyc(); b.ram_din = 8'hA1;
        chk("pz_c2_a", b.ram_a, 32'h41);
        cyc(); b.rdy = 1'b0; b.ram_din = 8'hEE; #1;
        chk("pz_c3_a", b.ram_a, 32'h42);
        chk("pz_c3_wr", 32'(b.ram_wr), 32'd0);
        cyc();
        chk("pz_c4_a", b.ram_a, 32'h42);
        cyc();
        chk("pz_c5_a", b.ram_a, 32'h42);
        cyc(); b.rdy = 1'b1; #1;
        chk("pz_replay_a", b.ram_a, 32'h41);
        chk("pz_c6_wr", 32'(b.ram_wr), 32'd0);
        cyc(); b.ram_din = 8'hB2;
        chk("pz_c7_a", b.ram_a, 32'h42);
        cyc(); b.ram_din = 8'hC3;
        chk("pz_c8_a", b.ram_a, 32'h43);
        cyc(); b.ram_din = 8'hD4;
        chk("pz_c9_a", b.ram_a, 32'd0);
        chk("pz_c9_done", 32'(b.if_done), 32'd0);
        cyc();
        chk("pz_c10_done", 32'(b.if_done), 32'd1);
        chk("pz_data", b.if_data, 32'hD4C3B2A1);
        chk("pz_c10_wr", 32'(b.ram_wr), 32'd0);
        b.if_req = 1'b0;
        cyc();
        chk("pz_c11_busy", 32'(b.busy), 32'd0);

        // reset in cycle 2 of a word store, then a fresh byte store
        b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_size = 2'd2;
        b.mem_addr = 32'h500; b.mem_wdata = 32'h11223344;
        cyc();
        chk("rs_c1_wr", 32'(b.ram_wr), 32'd1);
        chk("rs_c1_a", b.ram_a, 32'h500);
        cyc();
        chk("rs_c2_a", b.ram_a, 32'h501);
        rst = 1'b1; b.mem_req = 1'b0; b.mem_we = 1'b0;
        cyc();
        rst = 1'b0;
        chk("rs_c3_wr", 32'(b.ram_wr), 32'd0);
        chk("rs_c3_busy", 32'(b.busy), 32'd0);
        chk("rs_c3_done", 32'(b.mem_done), 32'd0);
        chk("rs_c3_rdata", b.mem_rdata, 32'd0);
        chk("rs_c3_if_data", b.if_data, 32'd0);
        cyc();
        chk("rs_c4_done", 32'(b.mem_done), 32'd0);
        b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_size = 2'd0;
        b.mem_addr = 32'h600; b.mem_wdata = 32'hAABBCC07;
        cyc();
        chk("nb_c1_wr", 32'(b.ram_wr), 32'd1);
        chk("nb_c1_a", b.ram_a, 32'h600);
        chk("nb_c1_dout", 32'(b.ram_dout), 32'h07);
        cyc();
        chk("nb_c2_done", 32'(b.mem_done), 32'd1);
        chk("nb_c2_wr", 32'(b.ram_wr), 32'd0);
        b.mem_req = 1'b0; b.mem_we = 1'b0;
        cyc();
        chk("nb_c3_busy", 32'(b.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Byte-serial memory scheduler between the CPU's two memory clients, instruction fetch and the MEM stage, and the single 8-bit RAM/IO bus. It grants one client at a time and splits each 1/2/4-byte access into per-byte bus cycles. Read data is assembled little-endian into a 32-bit word, and each transaction ends with a one-cycle done pulse. It honours the 2-cycle read latency, the 1-cycle write, the `rdy` pause and the no-duplicate-access rule for I/O space.

## Interface
Parameters:
- `MEM_FIRST`, default 1. 1: MEM beats IF when both request in the same cycle. 0: IF beats MEM.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  low: freeze all state.
- `if_req`  in  1  fetch request, held until `if_done`.
- `if_addr`  in  32  fetch address; always a 4-byte read.
- `if_done`  out  1  one-cycle pulse; `if_data` valid in that cycle.
- `if_data`  out  32  assembled instruction word.
- `mem_req`  in  1  MEM-stage request, held until `mem_done`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `mem_addr`  in  32  base address.
- `mem_wdata`  in  32  store data; byte i = `[8i+7:8i]`.
- `mem_done`  out  1  one-cycle pulse.
- `mem_rdata`  out  32  load data, zero-extended; sign extension belongs to MEM.
- `ram_din`  in  8  RAM/IO read byte.
- `ram_dout`  out  8  write byte.
- `ram_a`  out  32  byte address.
- `ram_wr`  out  1  1 = write.
- `busy`  out  1  high in any state other than IDLE.

## Operation
FSM states: IDLE, ISSUE, DRAIN, DONE.

IDLE
- Requests are sampled here.
- Grant goes to the higher-priority active requester.
- On grant, latch owner, base, byte count n (1/2/4), `we` and `wdata`.
- Go to ISSUE with index i = 0.

ISSUE, one byte per cycle
- Drive `ram_a` = base + i, computed in 32-bit modulo 2^32.
- Write: `ram_wr` = 1, `ram_dout` = wdata byte i.
- Read: `ram_wr` = 0; capture `ram_din` into byte i−1 of the assembly register when i ≥ 1.
- Exit at i = n−1: reads go to DRAIN, writes go to DONE.

DRAIN
- Read only.
- `ram_a` = 0, `ram_wr` = 0.
- Capture `ram_din` into byte n−1.
- Go to DONE.

DONE
- Owner's done = 1.
- Owner's data output shows the assembled word; upper unused bytes are 0.
- Requests are not sampled.
- Go to IDLE.

Output rules
- The data outputs (`if_data`, `mem_rdata`) hold their value until the next completion for that owner.
- In IDLE and DONE: `ram_a` = 0, `ram_wr` = 0, `ram_dout` = 0.

Bus access rules
- Each byte address of a transaction is driven exactly once, apart from a pause replay (below).
- No speculative or prefetch access, including to I/O space (`addr[17:16]` = 2'b11).
- No preemption: a granted transaction runs to DONE even if the other client requests.
- A requester must drop `req` no later than the edge at which it samples its done pulse. A `req` still high in the following IDLE cycle is treated as a new request.

Pause (`rdy` = 0)
- FSM, index, latches and assembly register hold.
- `ram_wr` is forced to 0; `ram_a` holds its last value.
- Done outputs are forced to 0. A done pulse interrupted by a pause is emitted on the first active cycle after it.
- Replay on resume: if the pause began in ISSUE with i ≥ 1 on a read, or in DRAIN, the first active cycle re-drives address base + (last outstanding index) without capturing. Normal sequencing, including that byte's capture, resumes the cycle after.
- Writes need no replay.

Reset
- State IDLE; index and owner 0.
- All outputs 0, including `if_data` and `mem_rdata`.
- Reset mid-transaction abandons it and emits no done.

## Timing
Cycle 0 is the cycle in which the request is sampled in IDLE.
- Word read: addresses driven in cycles 1–4; captures at the end of cycles 2, 3, 4 and 5 (DRAIN); done in cycle 6.
- Byte read: done in cycle 3. Half read: done in cycle 4.
- n-byte write: writes in cycles 1..n; done in cycle n+1.
- Back-to-back: after DONE there is one IDLE cycle before the next grant, so minimum spacing is done to next cycle-1 = 2 cycles.
- Simultaneous requests in IDLE: `MEM_FIRST` decides. The loser keeps `req` high and is granted in the IDLE cycle after the winner's DONE.
- A pause of p cycles adds p cycles to latency, plus 1 when a replay is needed.

## Test plan
- Word fetch at 0x00000010, RAM bytes 0x13,0x05,0x10,0x00 → `ram_a` sequence 0x10–0x13 in cycles 1–4; `if_done` in cycle 6; `if_data` = 0x00100513.
- Store word 0xDEADBEEF at 0x100 → cycles 1–4 carry `ram_wr` = 1, `ram_a` 0x100–0x103, `ram_dout` EF, BE, AD, DE; `mem_done` in cycle 5.
- `if_req` and `mem_req` (byte load at 0x30000, input 0x41) raised together, `MEM_FIRST` = 1 → MEM is served first; 0x30000 is driven exactly once; `mem_rdata` = 0x00000041; IF is granted in the IDLE cycle after `mem_done`, and `if_done` follows 6 cycles later.
- Half load at 0xFFFFFFFF → addresses 0xFFFFFFFF then 0x00000000; done in cycle 4.
- Word read with `rdy` low for 3 cycles after cycle 2 → one replay of base+1; the final word is correct; done in cycle 10; `ram_wr` stays 0 throughout.
- `rst` high in cycle 2 of a write → `ram_wr` = 0 in the next cycle; no `mem_done`; `busy` = 0; a new request is accepted normally.
